int_root: RTL
=============

Name: int_root

Overview:
- Parametrised integer root unit. Computes floor(sqrt(x)) or floor(cbrt(x)) of a W-bit unsigned operand, plus the remainder.
- Uses the digit-by-digit restoring method. Sqrt retires 2 bits per iteration; cbrt retires 3 bits per iteration.
- Serves as a multi-cycle accelerator behind a start/busy/done handshake.
- Generalises the fixed 8-bit cube-root unit: adds width, a sqrt mode, a remainder output and a done strobe.

Parameters:
- W, 16: operand width in bits; legal range 4..32.
- YW (localparam), (W+1)/2: result width, sized to fit the larger root (sqrt).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- x_bi  in  W  radicand, sampled only when a start is accepted.
- mode_i  in  1  0 = square root, 1 = cube root; sampled with x_bi.
- start_i  in  1  request; accepted only when busy_o = 0.
- busy_o  out  1  high from the cycle after acceptance until done_o.
- done_o  out  1  one-cycle pulse when results become valid.
- y_bo  out  YW  root, zero-extended.
- rem_bo  out  W  x - y^k, where k = 2 (sqrt) or 3 (cbrt).

Behaviour:
- Reset: busy_o=0, done_o=0, y_bo=0, rem_bo=0, FSM=IDLE, multiplier aborted.
  - Reset mid-operation discards all work.
  - Outputs return to 0 on the next edge.
- Parameters latched at acceptance:
  - k = mode_i ? 3 : 2.
  - N = ceil(W/k) iterations.
  - s0 = k*(N-1).
  - x_r = x_bi, y_r = 0, s = s0.
- States: IDLE, SHIFT, MUL, CALC, CMP, DONE.
- IDLE: on start_i=1, latch the parameters above and go to SHIFT. Otherwise hold; outputs keep their last values.
- SHIFT: y_r <= y_r << 1.
  - Sqrt: go to CALC.
  - Cbrt: launch the multiplier with y_r*(y_r+1), using the post-shift y, and go to MUL.
- MUL: wait for the multiplier done pulse, then capture product p and go to CALC. Exactly YW cycles.
- CALC: b <= (k==2) ? 2*y_r+1 : (p<<1)+p+1. Width 2*YW+2; no truncation.
- CMP:
  - If (x_r >> s) >= b: x_r <= x_r - (b << s) and y_r <= y_r + 1.
  - Comparing in the shifted-down domain means b<<s is never formed when it would exceed W bits.
  - If this was the last iteration (s==0): go to DONE. Otherwise s <= s - k and go to SHIFT.
- DONE: y_bo <= y_r, rem_bo <= x_r, done_o=1 for this cycle only, busy_o=0 from the next cycle, go to IDLE.
- Latency from the acceptance edge to the done_o cycle:
  - Sqrt: 3*N + 1 cycles.
  - Cbrt: N*(3+YW) + 1 cycles.
  - For W=16: sqrt 25, cbrt 67.
- Handshake:
  - start_i while busy_o=1 is ignored and not queued.
  - start_i in the DONE cycle is ignored.
  - start_i in the cycle after DONE is accepted.
- Boundaries:
  - x=0 gives y=0, rem=0.
  - x = 2^W-1 must not overflow any intermediate value.
  - Top digit group when W is not a multiple of k is padded with zeros implicitly via s0.
  - mode_i changes mid-operation have no effect.
- busy_o is a registered output, not decoded from the state.

Decomposition:
- Package int_root_pkg:
  - State encoding enum.
  - MODE_SQRT=1'b0 and MODE_CBRT=1'b1.
  - Function iter_count(W,k) returning ceil(W/k).
- Sub-module mult_seq:
  - Parametrised width M = YW; radix-2 shift-add.
  - Interface: start_i, a_bi, b_bi, busy_o, done_o (one pulse), y_bo[2M-1:0].
  - Fixed latency of M cycles; synchronous reset aborts it.
  - Reusable by later accelerators.

Test Plan:
- W=16, sqrt, x=65535 -> y=255, rem=510, done_o 25 cycles after acceptance, busy_o high for exactly those cycles.
- W=16, cbrt, x=65535 -> y=40, rem=1535. Then x=64000 -> y=40, rem=0. Then x=255 -> y=6, rem=39. Each takes 67 cycles.
- W=8, cbrt, x=27 -> y=3, rem=0. Same unit, sqrt x=0 -> y=0, rem=0. Exhaustive sweep of all 256 x in both modes against a software model.
- Pulse start_i with x=100 during a busy cbrt of x=1000 -> first result y=10, rem=0 is unaffected, no second done_o, busy_o low after DONE.
- Assert rst_i mid-cbrt at cycle 20 -> next edge shows busy_o=0, y_bo=0, rem_bo=0. A new sqrt x=144 then yields y=12, rem=0.
- Back-to-back: start_i held high continuously -> a new operation is accepted the cycle after each done_o, and y_bo is stable between done pulses.

Source files
------------

// File: rtl/int_root_pkg.sv
// Shared types and helpers for the integer root unit.
// Holds the FSM state encoding, mode codes and iteration-count helper.
package int_root_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_MUL,
        ST_CALC,
        ST_CMP,
        ST_DONE
    } state_e;

    localparam logic MODE_SQRT = 1'b0;
    localparam logic MODE_CBRT = 1'b1;

    // Number of k-bit digit groups needed to cover a w-bit operand.
    function automatic int iter_count(input int w, input int k);
        return (w + k - 1) / k;
    endfunction

endpackage

// File: rtl/mult_seq.sv
// Sequential radix-2 shift-add multiplier, fixed latency of M cycles.
// Ports: clk_i, rst_i (sync, active high, aborts), start_i,
//        a_bi/b_bi (M-bit operands), busy_o, done_o (1-cycle pulse),
//        y_bo (2M-bit product, valid from done_o until next start).
module mult_seq #(
    parameter int M = 8
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           start_i,
    input  logic [M-1:0]   a_bi,
    input  logic [M-1:0]   b_bi,
    output logic           busy_o,
    output logic           done_o,
    output logic [2*M-1:0] y_bo
);

    localparam int CW = $clog2(M + 1);

    logic [2*M-1:0] a_q, a_d;
    logic [M-1:0]   b_q, b_d;
    logic [2*M-1:0] acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [2*M-1:0] a_ext;

    // Bit 0 is retired on the start edge itself so that the product
    // is final, and done_o high, exactly M cycles after start.
    always_comb begin
        a_ext  = {{M{1'b0}}, a_bi};
        a_d    = a_q;
        b_d    = b_q;
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (start_i) begin
            acc_d  = b_bi[0] ? a_ext : '0;
            a_d    = a_ext << 1;
            b_d    = b_bi >> 1;
            cnt_d  = CW'(1);
            busy_d = (M > 1);
            done_d = (M == 1);
        end else if (busy_q) begin
            acc_d = acc_q + (b_q[0] ? a_q : '0);
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(M - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign y_bo   = acc_q;

endmodule

// File: rtl/int_root.sv
// Multi-cycle integer square / cube root with remainder (digit-by-digit).
// Ports: clk_i, rst_i (sync, active high), x_bi (radicand), mode_i
//        (0 sqrt, 1 cbrt), start_i, busy_o, done_o, y_bo (root), rem_bo.
module int_root
    import int_root_pkg::*;
#(
    parameter  int W  = 16,
    localparam int YW = (W + 1) / 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [W-1:0]  x_bi,
    input  logic          mode_i,
    input  logic          start_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [YW-1:0] y_bo,
    output logic [W-1:0]  rem_bo
);

    localparam int BW = 2 * YW + 2;
    localparam int SW = $clog2(W);
    localparam int NS = iter_count(W, 2);
    localparam int NC = iter_count(W, 3);
    localparam logic [SW-1:0] S0_SQRT = SW'(2 * (NS - 1));
    localparam logic [SW-1:0] S0_CBRT = SW'(3 * (NC - 1));

    state_e          state_q, state_d;
    logic            mode_q, mode_d;
    logic [W-1:0]    x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic [SW-1:0]   s_q, s_d;
    logic [2*YW-1:0] p_q, p_d;
    logic [BW-1:0]   b_q, b_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [YW-1:0]   yo_q, yo_d;
    logic [W-1:0]    rem_q, rem_d;

    logic            mul_start;
    logic [YW-1:0]   mul_a;
    logic [YW-1:0]   mul_b;
    logic            mul_busy;
    logic            mul_done;
    logic [2*YW-1:0] mul_y;

    logic [BW-1:0]   xs;
    logic            fit;
    logic [W-1:0]    x_sub;
    logic [YW-1:0]   y_inc;
    logic [BW-1:0]   p_w;

    // Cbrt needs y*(y+1) with the freshly shifted y.
    assign mul_a     = y_q << 1;
    assign mul_b     = mul_a + YW'(1);
    assign mul_start = (state_q == ST_SHIFT) && (mode_q == MODE_CBRT)
                     && !mul_busy;

    mult_seq #(.M(YW)) u_mul (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (mul_start),
        .a_bi    (mul_a),
        .b_bi    (mul_b),
        .busy_o  (mul_busy),
        .done_o  (mul_done),
        .y_bo    (mul_y)
    );

    // Trial compare happens against x shifted down, so b<<s is only
    // built when it is known to fit under x.
    always_comb begin
        xs    = BW'(x_q >> s_q);
        fit   = (xs >= b_q);
        x_sub = x_q - (W'(b_q) << s_q);
        y_inc = y_q + YW'(1);
        p_w   = BW'(p_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start_i) state_d = ST_SHIFT;
            ST_SHIFT: state_d = (mode_q == MODE_CBRT) ? ST_MUL : ST_CALC;
            ST_MUL:   if (mul_done) state_d = ST_CALC;
            ST_CALC:  state_d = ST_CMP;
            ST_CMP:   state_d = (s_q == '0) ? ST_DONE : ST_SHIFT;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mode_d = mode_q;
        x_d    = x_q;
        y_d    = y_q;
        s_d    = s_q;
        p_d    = p_q;
        b_d    = b_q;
        busy_d = busy_q;
        done_d = 1'b0;
        yo_d   = yo_q;
        rem_d  = rem_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    mode_d = mode_i;
                    x_d    = x_bi;
                    y_d    = '0;
                    s_d    = (mode_i == MODE_CBRT) ? S0_CBRT : S0_SQRT;
                    busy_d = 1'b1;
                end
            end
            ST_SHIFT: y_d = y_q << 1;
            ST_MUL: begin
                if (mul_done) p_d = mul_y;
            end
            ST_CALC: begin
                if (mode_q == MODE_SQRT) begin
                    b_d = BW'({y_q, 1'b1});
                end else begin
                    b_d = (p_w << 1) + p_w + BW'(1);
                end
            end
            ST_CMP: begin
                if (fit) begin
                    x_d = x_sub;
                    y_d = y_inc;
                end
                // Results are registered on entry to DONE so they are
                // valid in the same cycle as the done pulse.
                if (s_q == '0) begin
                    yo_d   = fit ? y_inc : y_q;
                    rem_d  = fit ? x_sub : x_q;
                    done_d = 1'b1;
                end else begin
                    s_d = s_q - ((mode_q == MODE_CBRT) ? SW'(3) : SW'(2));
                end
            end
            ST_DONE: busy_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mode_q <= MODE_SQRT;
            x_q    <= '0;
            y_q    <= '0;
            s_q    <= '0;
            p_q    <= '0;
            b_q    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            yo_q   <= '0;
            rem_q  <= '0;
        end else begin
            mode_q <= mode_d;
            x_q    <= x_d;
            y_q    <= y_d;
            s_q    <= s_d;
            p_q    <= p_d;
            b_q    <= b_d;
            busy_q <= busy_d;
            done_q <= done_d;
            yo_q   <= yo_d;
            rem_q  <= rem_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign y_bo   = yo_q;
    assign rem_bo = rem_q;

endmodule
